// File: rtl/ctl_pipe_stage.sv
// rtl/ctl_pipe_stage.sv - elastic multi-stage pipeline register for the decode control bundle
//
// Carries a WIDTH-bit control bundle through DEPTH valid/ready stages with
// back-pressure, bubble compression and flush. Empty stages always hold
// NOP_VALUE, so out_data reads NOP_VALUE whenever out_valid is low.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid, in_ready, in_data   upstream handshake and bundle
//   flush                     kill every in-flight bundle at the next edge
//   out_valid, out_ready, out_data downstream handshake and bundle
//   occupancy                 number of valid stages (0..DEPTH)
//   stall_cycles, bubble_cycles   saturating activity counters, present only
//                                 when CTL_PIPE_STATS_EN is defined
module ctl_pipe_stage #(
    parameter int               WIDTH     = 16,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
`ifdef CTL_PIPE_STATS_EN
    output logic [15:0]                  stall_cycles,
    output logic [15:0]                  bubble_cycles,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d     [DEPTH];
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] src_v;
    logic [WIDTH-1:0] src_d [DEPTH];

    assign src_v[0] = in_valid;
    assign src_d[0] = in_data;

    // Each stage's source is the stage before it; ready ripples back from the
    // output so a full pipe can still shift every cycle while out_ready is high.
    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        if (g > 0) begin : g_src
            assign src_v[g] = v[g-1];
            assign src_d[g] = d[g-1];
        end
        if (g == DEPTH-1) begin : g_last
            assign rdy[g] = !v[g] || out_ready;
        end else begin : g_mid
            assign rdy[g] = !v[g] || rdy[g+1];
        end
    end

    assign in_ready  = rdy[0] && !flush;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst || flush) begin
                v[i] <= 1'b0;
                d[i] <= NOP_VALUE;
            end else if (rdy[i]) begin
                // An invalid source turns into a bubble that carries NOP_VALUE.
                v[i] <= src_v[i];
                d[i] <= src_v[i] ? src_d[i] : NOP_VALUE;
            end
        end
    end

    logic [OCC_W-1:0] count;

    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + OCC_W'(v[i]);
        end
    end

    assign occupancy = count;

`ifdef CTL_PIPE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles  <= 16'h0000;
            bubble_cycles <= 16'h0000;
        end else begin
            if (v[DEPTH-1] && !out_ready && stall_cycles != 16'hFFFF) begin
                stall_cycles <= stall_cycles + 16'h0001;
            end
            if (!v[DEPTH-1] && bubble_cycles != 16'hFFFF) begin
                bubble_cycles <= bubble_cycles + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ctl_pipe_stage.sv
// tb/tb_ctl_pipe_stage.sv - self-checking bench for ctl_pipe_stage (DEPTH=2, WIDTH=16)
module tb_ctl_pipe_stage;

    localparam int          WIDTH = 16;
    localparam int          DEPTH = 2;
    localparam logic [15:0] NOP   = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  occupancy;
`ifdef CTL_PIPE_STATS_EN
    logic [15:0] stall_cycles;
    logic [15:0] bubble_cycles;
`endif

    ctl_pipe_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NOP_VALUE(NOP)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
`ifdef CTL_PIPE_STATS_EN
        .stall_cycles  (stall_cycles),
        .bubble_cycles (bubble_cycles),
`endif
        .occupancy     (occupancy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: in-flight bundles oldest first, each with a slot index.
    logic [15:0] mq_d [$];
    int          mq_p [$];
    int          np   [$];
    int          m_stall  = 0;
    int          m_bubble = 0;
    logic        m_ov;
    logic [15:0] m_od;
    int          m_occ;
    logic        m_ir;

    // A bundle advances one slot if the slot ahead is free after the older
    // bundles have moved; slot DEPTH means "left through the output".
    task automatic model_eval();
        int limit;
        np.delete();
        limit = out_ready ? DEPTH + 1 : DEPTH;
        foreach (mq_p[k]) begin
            int n;
            n = (mq_p[k] + 1 < limit) ? mq_p[k] + 1 : mq_p[k];
            np.push_back(n);
            limit = n;
        end
        m_ov  = (mq_p.size() > 0) && (mq_p[0] == DEPTH - 1);
        m_od  = m_ov ? mq_d[0] : NOP;
        m_occ = mq_p.size();
        m_ir  = !flush && (np.size() == 0 || np[np.size()-1] > 0);
    endtask

    task automatic model_update();
        model_eval();
        if (rst) begin
            mq_d.delete();
            mq_p.delete();
            m_stall  = 0;
            m_bubble = 0;
        end else begin
            if (m_ov && !out_ready && m_stall < 65535) m_stall++;
            if (!m_ov && m_bubble < 65535) m_bubble++;
            if (flush) begin
                mq_d.delete();
                mq_p.delete();
            end else begin
                foreach (mq_p[k]) mq_p[k] = np[k];
                if (mq_p.size() > 0 && mq_p[0] == DEPTH) begin
                    void'(mq_p.pop_front());
                    void'(mq_d.pop_front());
                end
                if (m_ir && in_valid) begin
                    mq_d.push_back(in_data);
                    mq_p.push_back(0);
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic [15:0] dd,
                         input logic f, input logic orr);
        @(negedge clk);
        rst       = r;
        in_valid  = iv;
        in_data   = dd;
        flush     = f;
        out_ready = orr;
        #1;
    endtask

    task automatic edge_tick();
        @(posedge clk);
        model_update();
    endtask

    task automatic check_model(input string tag);
        model_eval();
        check({tag, "_ov"},  out_valid, m_ov);
        check({tag, "_od"},  out_data,  m_od);
        check({tag, "_occ"}, occupancy, m_occ);
        check({tag, "_ir"},  in_ready,  m_ir);
`ifdef CTL_PIPE_STATS_EN
        check({tag, "_stall"},  stall_cycles,  m_stall);
        check({tag, "_bubble"}, bubble_cycles, m_bubble);
`endif
    endtask

    typedef struct {
        logic        r;
        logic        iv;
        logic [15:0] dd;
        logic        f;
        logic        orr;
        logic        e_ov;
        logic [15:0] e_od;
        logic [1:0]  e_occ;
        logic        e_ir;
    } vec_t;

    vec_t tbl [19];

    initial begin
        // rst iv data fl ordy | ov od occ ir
        tbl[0]  = '{0, 1, 16'hA001, 0, 0,  0, 16'h0000, 2'd0, 1};
        tbl[1]  = '{0, 1, 16'hA002, 0, 0,  0, 16'h0000, 2'd1, 1};
        tbl[2]  = '{0, 1, 16'hA003, 0, 0,  1, 16'hA001, 2'd2, 0};
        tbl[3]  = '{0, 1, 16'hA003, 0, 1,  1, 16'hA001, 2'd2, 1};
        tbl[4]  = '{0, 0, 16'h0000, 0, 1,  1, 16'hA002, 2'd2, 1};
        tbl[5]  = '{0, 0, 16'h0000, 0, 1,  1, 16'hA003, 2'd1, 1};
        tbl[6]  = '{0, 0, 16'h0000, 0, 1,  0, 16'h0000, 2'd0, 1};
        tbl[7]  = '{0, 1, 16'hB001, 0, 0,  0, 16'h0000, 2'd0, 1};
        tbl[8]  = '{0, 0, 16'h0000, 0, 0,  0, 16'h0000, 2'd1, 1};
        tbl[9]  = '{0, 1, 16'hB002, 0, 0,  1, 16'hB001, 2'd1, 1};
        tbl[10] = '{0, 1, 16'hB003, 0, 0,  1, 16'hB001, 2'd2, 0};
        tbl[11] = '{0, 1, 16'hB003, 1, 1,  1, 16'hB001, 2'd2, 0};
        tbl[12] = '{0, 0, 16'h0000, 0, 1,  0, 16'h0000, 2'd0, 1};
        tbl[13] = '{0, 1, 16'hC001, 1, 1,  0, 16'h0000, 2'd0, 0};
        tbl[14] = '{0, 0, 16'h0000, 0, 1,  0, 16'h0000, 2'd0, 1};
        tbl[15] = '{0, 1, 16'hD001, 0, 0,  0, 16'h0000, 2'd0, 1};
        tbl[16] = '{0, 1, 16'hD002, 0, 0,  0, 16'h0000, 2'd1, 1};
        tbl[17] = '{1, 1, 16'hD003, 0, 0,  1, 16'hD001, 2'd2, 0};
        tbl[18] = '{0, 0, 16'h0000, 0, 1,  0, 16'h0000, 2'd0, 1};

        // Reset from power-up.
        drive(1, 0, 16'h0, 0, 0);
        edge_tick();
        drive(0, 0, 16'h0, 0, 1);
        check("rst_ov",  out_valid, 1'b0);
        check("rst_od",  out_data,  NOP);
        check("rst_occ", occupancy, 2'd0);
        check("rst_ir",  in_ready,  1'b1);
        edge_tick();

        // Free-flowing stream 1..8: first output two cycles after first accept.
        for (int c = 0; c <= 10; c++) begin
            logic        e_ov;
            logic [1:0]  e_occ;
            drive(0, c < 8, (c < 8) ? 16'(c + 1) : 16'h0, 0, 1);
            e_ov  = (c >= 2 && c <= 9);
            e_occ = (c == 0) ? 2'd0 : (c == 1) ? 2'd1 : (c <= 8) ? 2'd2 : (c == 9) ? 2'd1 : 2'd0;
            check($sformatf("strm%0d_ov", c),  out_valid, e_ov);
            check($sformatf("strm%0d_od", c),  out_data,  e_ov ? 16'(c - 1) : NOP);
            check($sformatf("strm%0d_occ", c), occupancy, e_occ);
            check($sformatf("strm%0d_ir", c),  in_ready,  1'b1);
            edge_tick();
        end

        // Stall, bubble compression, flush, reset mid-stream.
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].r, tbl[i].iv, tbl[i].dd, tbl[i].f, tbl[i].orr);
            check($sformatf("tbl%0d_ov", i),  out_valid, tbl[i].e_ov);
            check($sformatf("tbl%0d_od", i),  out_data,  tbl[i].e_od);
            check($sformatf("tbl%0d_occ", i), occupancy, tbl[i].e_occ);
            check($sformatf("tbl%0d_ir", i),  in_ready,  tbl[i].e_ir);
            edge_tick();
        end

        // Random traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                  16'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
            check_model($sformatf("rnd%0d", c));
            edge_tick();
        end

`ifdef CTL_PIPE_STATS_EN
        drive(1, 0, 16'h0, 0, 0);
        edge_tick();
        for (int c = 0; c < 2; c++) begin
            drive(0, 1, 16'hE000 + 16'(c), 0, 0);
            edge_tick();
        end
        for (int c = 0; c < 5; c++) begin
            drive(0, 0, 16'h0, 0, 0);
            edge_tick();
        end
        drive(0, 0, 16'h0, 1, 1);
        edge_tick();
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 16'h0, 0, 1);
            edge_tick();
        end
        drive(0, 0, 16'h0, 0, 1);
        check("stats_stall5",  stall_cycles,  16'd5);
        check("stats_bubble5", bubble_cycles, 16'd5);
        check_model("stats_seq");
        edge_tick();

        for (int c = 0; c < 2; c++) begin
            drive(0, 1, 16'hF000 + 16'(c), 0, 0);
            edge_tick();
        end
        drive(0, 0, 16'h0, 0, 0);
        for (int c = 0; c < 70000; c++) begin
            edge_tick();
        end
        drive(0, 0, 16'h0, 1, 0);
        check("stats_sat", stall_cycles, 16'hFFFF);
        check_model("stats_sat");
        edge_tick();
        drive(0, 0, 16'h0, 0, 1);
        check("stats_flush_keeps", stall_cycles, 16'hFFFF);
        check_model("stats_post_flush");
        edge_tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ctl_pipe_stage.md
Name: ctl_pipe_stage

Overview:
- Parametrised successor to the fixed per-phase control registers.
- Carries a WIDTH-bit control bundle (ALU selects, mem read, opcode, Ra/Rb) through DEPTH elastic stages with valid/ready handshake, stall back-pressure and flush.
- Sits between decode and the execute/memory phases of the simple pipeline. Replaces the hand-written phaseN control registers and adds bubble insertion, which they lack.

Parameters:
- WIDTH, 16: bits in the control bundle (1..64).
- DEPTH, 2: number of register stages (1..4).
- NOP_VALUE, 0: WIDTH-bit value held by every empty stage; loaded on reset and on flush.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  upstream presents in_data.
- in_ready  output  1  stage 0 can accept this cycle.
- in_data  input  WIDTH  control bundle from decode.
- flush  input  1  discard all in-flight bundles (branch/hazard kill).
- out_valid  output  1  last stage holds a valid bundle.
- out_ready  input  1  downstream consumes out_data this cycle.
- out_data  output  WIDTH  last-stage bundle; equals NOP_VALUE when out_valid=0.
- occupancy  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Reset:
  - All stage valid bits = 0 and all stage data = NOP_VALUE on the first clk edge with rst=1.
  - Outputs: out_valid=0, out_data=NOP_VALUE, occupancy=0, in_ready=1.
  - Reset mid-transfer drops all bundles and has priority over flush and all handshakes.
- Stage i holds (v[i], d[i]); stage DEPTH-1 drives out_*.
  - ready[DEPTH-1] = !v[DEPTH-1] | out_ready.
  - ready[i] = !v[i] | ready[i+1].
  - in_ready = ready[0] & !flush. Ready is a combinational chain, so a full pipe with out_ready=1 accepts every cycle.
- Advance when not flushing:
  - Stage i loads from stage i-1 (stage 0 from in_*) when ready[i]=1.
  - If the source is invalid, stage i becomes v=0, d=NOP_VALUE (bubble).
  - A stage holds when ready[i]=0.
- Latency: a bundle accepted at edge N appears on out_* after edge N+DEPTH-1, i.e. visible during cycle N+DEPTH. With no stalls, throughput is 1 bundle/clk.
- Stall: with out_ready=0, bubbles compress. Upstream valid bundles move into empty stages until all are full, then in_ready=0.
- Data is never modified. A bundle leaves only via out handshake (out_valid & out_ready), flush or reset.
- Flush, in a cycle with flush=1:
  - in_ready=0, and no input is accepted.
  - out handshake in that cycle still completes if out_ready=1, so the presented bundle counts as consumed.
  - At the next edge, all v=0 and all d=NOP_VALUE.
  - flush held for several cycles keeps the pipe empty.
- occupancy = popcount of v[], updated with the stage registers. Range 0..DEPTH.
- Stage valid bits and occupancy change only on clk edges. The only combinational outputs are in_ready (from out_ready/flush) and the out_ready→in_ready path.
- Boundaries:
  - Full and simultaneous out_ready=1 / in_valid=1: shift through, occupancy unchanged.
  - Empty: out_valid=0, out_data=NOP_VALUE regardless of in_valid in the same cycle (no bypass).
  - DEPTH=1: behaves as a single registered stage with in_ready = !v | out_ready.

Optional Feature:
- Macro CTL_PIPE_STATS_EN.
- When defined, adds outputs stall_cycles[15:0] and bubble_cycles[15:0]:
  - stall_cycles increments each clk with out_valid=1 & out_ready=0.
  - bubble_cycles increments each clk with out_valid=0 & rst=0.
  - Both saturate at 16'hFFFF and clear on rst; flush does not clear them.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset with DEPTH=2, NOP_VALUE=16'h0000: after one rst edge, expect out_valid=0, out_data=16'h0000, occupancy=0, in_ready=1. Repeat rst mid-stream with 2 valid bundles → same result.
- Stream 16'h0001..16'h0008 with in_valid=1, out_ready=1 → first out_valid at cycle 2 after first accept, then one bundle per clk in order, occupancy steady at 2.
- Hold out_ready=0 and offer 16'hA001, 16'hA002, 16'hA003 → first two accepted, in_ready=0 on the third, occupancy=2. Release out_ready → A001, A002, A003 emerge in order with no loss or duplication.
- Insert in_valid gaps (pattern 1,0,1) with out_ready=0 → bubble compresses, occupancy reaches 2, out_data=16'h0000 while out_valid=0.
- flush=1 with occupancy=2, out_ready=1, in_valid=1 → current out bundle handshakes, input not accepted (in_ready=0), next cycle occupancy=0, out_data=NOP_VALUE.
- With CTL_PIPE_STATS_EN defined: 5 stalled cycles then 3 empty cycles → stall_cycles=5, bubble_cycles=3 (plus initial empties). Force 70000 stall cycles → stall_cycles holds 16'hFFFF.
